// File: rtl/upsample_share_arbiter_if.sv
// Handshake bundle between the upsampler share arbiter, its two
// requesters and the shared 2x upsampler.
interface upsample_share_arbiter_if #(
    parameter int DATA_WIDTH = 16
);
    logic [1:0]            req;
    logic [1:0]            grant;
    logic [DATA_WIDTH-1:0] s0_data;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s0_valid;
    logic                  s1_valid;
    logic                  s0_ready;
    logic                  s1_ready;
    logic [DATA_WIDTH-1:0] m0_data;
    logic [DATA_WIDTH-1:0] m1_data;
    logic                  m0_valid;
    logic                  m1_valid;
    logic                  m0_ready;
    logic                  m1_ready;
    logic                  up_start;
    logic [DATA_WIDTH-1:0] up_data_in;
    logic                  up_valid_in;
    logic                  up_ready_in;
    logic [DATA_WIDTH-1:0] up_data_out;
    logic                  up_valid_out;
    logic                  up_ready_out;
    logic                  up_done;
    logic                  err_len;
    logic                  owner_busy;

    modport slave (
        input  req,
        input  s0_data, s1_data, s0_valid, s1_valid,
        input  m0_ready, m1_ready,
        input  up_ready_in, up_data_out, up_valid_out, up_done,
        output grant,
        output s0_ready, s1_ready,
        output m0_data, m1_data, m0_valid, m1_valid,
        output up_start, up_data_in, up_valid_in, up_ready_out,
        output err_len, owner_busy
    );

    modport master (
        output req,
        output s0_data, s1_data, s0_valid, s1_valid,
        output m0_ready, m1_ready,
        output up_ready_in, up_data_out, up_valid_out, up_done,
        input  grant,
        input  s0_ready, s1_ready,
        input  m0_data, m1_data, m0_valid, m1_valid,
        input  up_start, up_data_in, up_valid_in, up_ready_out,
        input  err_len, owner_busy
    );
endinterface

// File: rtl/upsample_share_arbiter.sv
// Frame-level round-robin arbiter sharing one serial 2x upsampler
// between two requesters, with output beat counting per frame.
module upsample_share_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 4,
    parameter int IN_LEN     = 8,
    parameter int OUT_BEATS  = 2 * IN_LEN * CHANNELS
) (
    input logic clk,
    input logic rst_n,
    upsample_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        RELEASE
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        owner_q, owner_d;
    logic        prio_q,  prio_d;
    logic        err_q,   err_d;
    logic [15:0] cnt_q,   cnt_d;

    logic                  act;
    logic                  in_hs;
    logic                  out_hs;
    logic                  win;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  sel_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        // prio_q set means requester 1 wins a tie
        win     = bus.req[1] & (~bus.req[0] | prio_q);
        if (out_hs && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    owner_d = win;
                    grant_d = win ? 2'b10 : 2'b01;
                    state_d = START;
                end
            end
            START: begin
                if (in_hs) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.up_done) begin
                    // a beat landing with up_done is already in cnt_d
                    err_d   = err_q | (cnt_d != 16'(OUT_BEATS));
                    grant_d = 2'b00;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                cnt_d   = 16'd0;
                prio_d  = ~owner_q;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        act       = (state_q == START) || (state_q == RUN);
        sel_data  = owner_q ? bus.s1_data  : bus.s0_data;
        sel_valid = owner_q ? bus.s1_valid : bus.s0_valid;
        sel_ready = owner_q ? bus.m1_ready : bus.m0_ready;

        bus.grant        = grant_q;
        bus.err_len      = err_q;
        bus.owner_busy   = (state_q != IDLE);
        bus.up_start     = (state_q == START);
        bus.up_valid_in  = act & sel_valid;
        bus.up_data_in   = act ? sel_data : '0;
        bus.up_ready_out = act & sel_ready;

        in_hs  = bus.up_valid_in & bus.up_ready_in;
        out_hs = bus.up_valid_out & bus.up_ready_out;

        bus.s0_ready = ~owner_q & in_hs;
        bus.s1_ready =  owner_q & in_hs;
        bus.m0_valid = act & ~owner_q & bus.up_valid_out;
        bus.m1_valid = act &  owner_q & bus.up_valid_out;
        bus.m0_data  = (act & ~owner_q) ? bus.up_data_out : '0;
        bus.m1_data  = (act &  owner_q) ? bus.up_data_out : '0;
    end
endmodule
